// File: rtl/uart_frame_parser.sv
// Deframes a UART byte stream: SYNC, LEN, payload, XOR checksum. Verified payloads
// are replayed from an internal buffer on a valid/ready stream; faults pulse err_*.
module uart_frame_parser #(
  parameter int unsigned             DATA_WIDTH   = 8,
  parameter int unsigned             MAX_LEN      = 16,
  parameter logic [DATA_WIDTH-1:0]   SYNC_BYTE    = 8'hA5,
  parameter int unsigned             TIMEOUT_CLKS = 20000
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx_dv,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [7:0]            m_len,
  output logic                  frame_ok,
  output logic                  err_chk,
  output logic                  err_len,
  output logic                  err_timeout,
  output logic                  err_overrun,
  output logic [2:0]            dbg_state
);

  // Stream handshake: a byte transfers on every clk edge where m_valid && m_ready;
  // m_valid never drops and m_data/m_last/m_len never change until that transfer.

  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_q, len_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  wr_en;
  logic                  ok_d, err_chk_d, err_len_d, err_tmo_d, err_ovr_d;
  logic [DATA_WIDTH-1:0] mem_q [MAX_LEN];
  logic [7:0]            len_in;
  logic                  rd_last;

  assign len_in    = 8'(rx_data);
  assign rd_last   = (8'(rd_q) == len_q - 8'd1);
  assign m_valid   = (state_q == S_OUT);
  assign m_last    = m_valid && rd_last;
  assign m_data    = m_valid ? mem_q[rd_q[AW-1:0]] : '0;
  assign m_len     = m_valid ? len_q : '0;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    acc_d     = acc_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    tmo_d     = '0;
    wr_en     = 1'b0;
    ok_d      = 1'b0;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_dv && rx_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_dv) begin
          if (len_in == 8'd0 || len_in > MAX_LEN8) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d   = len_in;
            acc_d   = rx_data;
            wr_d    = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_dv) begin
          wr_en = 1'b1;
          acc_d = acc_q ^ rx_data;
          wr_d  = wr_q + IW'(1);
          if (8'(wr_q) == len_q - 8'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_dv) begin
          if (rx_data == acc_q) begin
            rd_d    = '0;
            state_d = S_OUT;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_OUT: begin
        // Bytes arriving while the buffer drains are dropped, never parsed.
        if (rx_dv) err_ovr_d = 1'b1;
        if (m_ready) begin
          rd_d = rd_q + IW'(1);
          if (rd_last) begin
            ok_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte in the expiry cycle takes priority over the timeout.
    if ((state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) && !rx_dv) begin
      if (tmo_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      tmo_q       <= '0;
      frame_ok    <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      tmo_q       <= tmo_d;
      frame_ok    <= ok_d;
      err_chk     <= err_chk_d;
      err_len     <= err_len_d;
      err_timeout <= err_tmo_d;
      err_overrun <= err_ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= rx_data;
  end

endmodule
